// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the fetch PC sequencer.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = '0;

endpackage

// File: rtl/pc_sequencer_take_logic.sv
// Taken/not-taken resolution for the control-flow instruction sitting in EX.
module pc_take_logic (
    input  logic ex_valid,
    input  logic branch,
    input  logic btype,
    input  logic jump,
    input  logic neg,
    input  logic zero,
    output logic take
);

    always_comb begin
        take = ex_valid & (jump | (branch & (btype ? neg : zero)));
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter sequencer: increment, stall hold, redirect with
// refetch penalty, and halt/resume.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned          ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0]    RESET_PC     = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned          PC_STEP      = 1,
    parameter int unsigned          FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_stall,
    input  logic              in_halt,
    input  logic              in_resume,
    input  logic              in_imem_ready,
    input  logic              in_ex_valid,
    input  logic              in_ctrl_branch,
    input  logic              in_ctrl_btype,
    input  logic              in_ctrl_jump,
    input  logic              in_ctrl_neg,
    input  logic              in_ctrl_zero,
    input  logic [ADDR_W-1:0] in_target,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_fetch_valid,
    output logic              out_flush,
    output logic              out_if_hold,
    output logic [1:0]        out_state
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        cnt;
    logic              take;
    logic              in_run;
    logic              advance;

    pc_take_logic u_take (
        .ex_valid (in_ex_valid),
        .branch   (in_ctrl_branch),
        .btype    (in_ctrl_btype),
        .jump     (in_ctrl_jump),
        .neg      (in_ctrl_neg),
        .zero     (in_ctrl_zero),
        .take     (take)
    );

    // Controls are gated by rst_n so nothing leaves the block while in reset.
    always_comb begin
        in_run          = rst_n & (state == ST_RUN);
        advance         = ~in_stall & in_imem_ready;
        out_flush       = in_run & take;
        out_fetch_valid = in_run & ~take & ~in_halt & advance;
        out_if_hold     = in_run & ~take & ~in_halt & ~advance;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (take) begin
                        pc <= in_target;
                        if (FLUSH_CYCLES > 0) begin
                            state <= ST_FLUSH;
                            cnt   <= 4'(FLUSH_CYCLES - 1);
                        end
                    end else if (in_halt) begin
                        state <= ST_HALT;
                    end else if (advance) begin
                        pc <= pc + ADDR_W'(PC_STEP);
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HALT: begin
                    if (in_resume) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign out_pc    = pc;
    assign out_state = state;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the fetch program counter and sequences it through normal increment, stall hold, control-flow redirect with refetch penalty, and halt/resume.
- Resolves the taken/not-taken decision for the control-flow instruction in EX, from the branch, btype, jump, neg and zero control bits.
- Drives the instruction-memory fetch address and the kill/hold controls for the IF/ID and ID/EX pipeline registers.

Parameters:
- ADDR_W, 32, width of the PC and the target address.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, increment per sequential fetch (word addressed).
- FLUSH_CYCLES, 2, bubble cycles after a redirect before fetch resumes (0..15; 0 means no penalty).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_stall  in  1  hazard stall; hold PC and IF/ID.
- in_halt  in  1  request halt; sampled only in RUN.
- in_resume  in  1  leave HALT.
- in_imem_ready  in  1  instruction memory accepts a fetch this cycle.
- in_ex_valid  in  1  EX stage holds a valid instruction.
- in_ctrl_branch  in  1  conditional branch.
- in_ctrl_btype  in  1  condition select: 0 = zero, 1 = neg.
- in_ctrl_jump  in  1  unconditional jump.
- in_ctrl_neg  in  1  ALU negative flag.
- in_ctrl_zero  in  1  ALU zero flag.
- in_target  in  ADDR_W  redirect address from EX.
- out_pc  out  ADDR_W  current fetch address.
- out_fetch_valid  out  1  fetch at out_pc is issued this cycle.
- out_flush  out  1  kill IF/ID and ID/EX.
- out_if_hold  out  1  hold IF/ID.
- out_state  out  2  RUN=0, FLUSH=1, HALT=2.

Behaviour:
- Reset: synchronous and active-low.
  - On the clock edge with rst_n=0: out_pc=RESET_PC, state RUN, flush counter 0.
  - While rst_n=0, force out_fetch_valid=0, out_flush=0, out_if_hold=0 combinationally.
  - A reset asserted mid-FLUSH or in HALT returns to RUN at RESET_PC.
- Take decision (combinational): take = in_ex_valid & (in_ctrl_jump | (in_ctrl_branch & (in_ctrl_btype ? in_ctrl_neg : in_ctrl_zero))).
- Priority: reset > take > halt > stall/imem_ready.
- RUN state:
  - take=1:
    - out_flush=1 in the same cycle; out_fetch_valid=0.
    - Next cycle: out_pc=in_target.
    - If FLUSH_CYCLES>0, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
  - else in_halt=1: next state HALT, PC held, out_fetch_valid=0.
  - else in_stall=1 or in_imem_ready=0: PC held, out_if_hold=1, out_fetch_valid=0.
  - else: out_fetch_valid=1, next out_pc = out_pc+PC_STEP, mod 2^ADDR_W (wraps silently).
- FLUSH state:
  - out_fetch_valid=0, out_flush=0, PC held at the target.
  - Counter decrements each cycle; at 0, next state RUN.
  - take, in_halt and in_stall are ignored here; the EX stage is already flushed.
  - Penalty: exactly FLUSH_CYCLES fetch-less cycles after the take cycle.
- HALT state:
  - PC held, out_fetch_valid=0.
  - take is ignored.
  - in_resume=1: next state RUN, and fetch resumes at the held PC.
- Simultaneous take and in_halt: take wins; the halt is dropped and must be reasserted.
- Simultaneous take and in_stall: take wins (the redirect overrides the stall).
- Outputs out_pc and out_state are registered; out_fetch_valid, out_flush and out_if_hold are combinational from state and inputs.

Decomposition:
- Shared package holds:
  - state encodings ST_RUN=2'd0, ST_FLUSH=2'd1, ST_HALT=2'd2;
  - the default ADDR_W and RESET_PC constants.
- One sub-module, pc_take_logic: the pure combinational take equation. It is instantiated once here and is reusable by the verification model.

Test Plan:
- Reset then 4 idle cycles (stall=0, ready=1) -> out_pc 0,1,2,3,4; out_fetch_valid=1 from the first post-reset cycle.
- branch=1, btype=0, zero=1, ex_valid=1, target=0x40 at pc=5 -> out_flush=1 that cycle; out_pc=0x40 next; fetch_valid=0 for 2 cycles; then fetch at 0x40, 0x41.
- branch=1, btype=1, zero=1, neg=0 -> no redirect and no flush, PC increments; repeat with neg=1 -> redirect.
- in_stall=1 for 3 cycles at pc=8 -> out_pc stays 8, out_if_hold=1, fetch_valid=0; then increments to 9.
- in_halt and jump (target 0x10) in the same cycle -> redirect to 0x10, state FLUSH not HALT; later in_halt -> HALT; jump ignored; in_resume -> RUN, fetch at the held PC.
- ADDR_W=8: pc=0xFF increments to 0x00. Also assert rst_n=0 mid-FLUSH -> out_state=0, out_pc=RESET_PC on the next edge.
